turbo_iter_ctrl: RTL and testbench
==================================

Name: turbo_iter_ctrl

Overview:
- Parametrised turbo-decoder frame controller and LLR buffer.
- Loads one frame of systematic, parity-1 and parity-2 soft values as bit-planes. Sequences an external SISO through alternating DEC1/DEC2 half-iterations, applying a fixed interleaver permutation to the systematic and extrinsic values.
- Forms hard decisions after each full iteration and stops on max iterations or early convergence.
- Presents the K decoded bits through a valid/ready output.

Parameters:
K, 5, information bits per frame
TAIL, 2, termination symbols; N = K+TAIL symbol positions
LLR_W, 4, channel LLR width (signed two's complement), equal to the number of load beats
EXT_W, 10, extrinsic LLR width (signed)
IDX_W, 3, permutation index width (2^IDX_W >= N)
PERM, 21'b100001101010110011000, packed interleaver; entry i at bits [i*IDX_W +: IDX_W] is the source index for interleaved position i (default 0,3,6,2,5,1,4)
ITER_W, 6, iteration counter width

Ports:
clk_p_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
in_valid_i  in  1  load beat valid
in_ready_o  out  1  load beat accepted
data_i  in  3*N  one bit-plane: [3N-1:2N] sys, [2N-1:N] par1, [N-1:0] par2; bit j of each field = position j
max_iter_i  in  ITER_W  full-iteration limit, sampled on first load beat; 0 treated as 1
early_en_i  in  1  enable early termination, sampled with max_iter_i
siso_start_o  out  1  one-cycle SISO launch pulse
siso_sel_o  out  1  0 = DEC1, 1 = DEC2
siso_sys_o  out  N*LLR_W  sys LLRs (interleaved for DEC2)
siso_enc_o  out  N*LLR_W  par1 (DEC1) or par2 (DEC2)
siso_ext_o  out  N*EXT_W  a-priori extrinsic
siso_done_i  in  1  SISO result valid
siso_ext_i  in  N*EXT_W  SISO extrinsic output
out_valid_o  out  1  decoded frame valid
out_ready_i  in  1  consumer accepts
data_o  out  K  decoded bits, position j at bit j
iter_used_o  out  ITER_W  full iterations performed

Behaviour:
- Reset values: all outputs 0 except in_ready_o = 1; state IDLE; buffers, ext12, ext21 and prev_hard cleared.
- States: IDLE, LOAD, DEC1, DEC2, CHECK, OUT.
- in_ready_o = 1 only in IDLE and LOAD.
- Load: a beat is accepted on in_valid_i & in_ready_o.
  - Beat b (0..LLR_W-1) writes bit b of every symbol; beat 0 is the LSB plane.
  - The first beat moves IDLE→LOAD (LOAD when LLR_W > 1) and samples max_iter_i and early_en_i.
  - The last beat moves to DEC1, clears iter_cnt and zeroes ext21.
- DEC1:
  - Entry cycle: siso_start_o = 1, siso_sel_o = 0, sys = natural order, enc = par1, ext = deinterleave(ext21).
  - Wait for siso_done_i, which is ignored in the start cycle. On done, latch siso_ext_i into ext12 and go to DEC2.
- DEC2:
  - Entry cycle: siso_start_o = 1, siso_sel_o = 1, sys[i] = sys[PERM[i]], enc = par2, ext[i] = ext12[PERM[i]].
  - On done, latch ext21 (interleaved order) and go to CHECK.
- siso_* data outputs are registered and held stable from the start pulse until done.
- CHECK (1 cycle):
  - iter_cnt += 1.
  - For each natural position j: L = sext(sys[j]) + ext12[j] + ext21[PERM^-1(j)], computed at EXT_W+2 bits with no saturation. hard[j] = (L > 0); L == 0 gives 0.
  - Go to OUT if iter_cnt == max(max_iter_i, 1), or if early_en & iter_cnt >= 2 & hard == prev_hard. Otherwise prev_hard <= hard and go to DEC1.
- OUT: out_valid_o = 1; data_o = hard[K-1:0]; iter_used_o = iter_cnt. All three hold until out_ready_i, then go to IDLE with out_valid_o = 0 the next cycle.
- Simultaneous events: in_valid_i in OUT is not accepted. siso_done_i outside DEC1/DEC2 is ignored.
- ITER_W counter never wraps, because the limit is bounded by max_iter_i.
- Reset asserted mid-frame: immediately returns to IDLE, drops siso_start_o and out_valid_o, and discards the partial load.

Test Plan:
- Reset then 4 beats of all-ones sys (sys = -1), par = 0, max_iter = 1, SISO model returns ext = 0 → one DEC1 and one DEC2 pulse; out_valid with data_o = 5'b00000, iter_used = 1.
- sys = +3 at all positions, SISO ext = +1, max_iter = 3, early_en = 0 → exactly 6 start pulses alternating sel 0/1; data_o = 5'b11111, iter_used = 3.
- Same frame with early_en = 1, max_iter = 10 → stops at iteration 2 with iter_used = 2.
- Positional sys LLRs 0..6 → siso_sys_o in DEC2 carries positions ordered 0,3,6,2,5,1,4; DEC1 ext equals the deinterleaved DEC2 output.
- out_ready_i held low for 5 cycles → data_o and out_valid_o stable throughout; in_ready_o = 0 until the handshake completes.
- reset_n_i pulsed during DEC2 and during beat 2 of a load → IDLE with all outputs at reset values; the next full frame decodes correctly.

Source files
------------

// File: rtl/turbo_iter_ctrl.sv
// Turbo-decoder frame controller: loads bit-plane LLRs, drives an external SISO
// through DEC1/DEC2 half-iterations, forms hard decisions and hands out the frame.
module turbo_iter_ctrl #(
    parameter int K      = 5,
    parameter int TAIL   = 2,
    parameter int LLR_W  = 4,
    parameter int EXT_W  = 10,
    parameter int IDX_W  = 3,
    parameter logic [(K+TAIL)*IDX_W-1:0] PERM = 21'b100001101010110011000,
    parameter int ITER_W = 6
) (
    input  logic                        clk_p_i,
    input  logic                        reset_n_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [3*(K+TAIL)-1:0]       data_i,
    input  logic [ITER_W-1:0]           max_iter_i,
    input  logic                        early_en_i,
    output logic                        siso_start_o,
    output logic                        siso_sel_o,
    output logic [(K+TAIL)*LLR_W-1:0]   siso_sys_o,
    output logic [(K+TAIL)*LLR_W-1:0]   siso_enc_o,
    output logic [(K+TAIL)*EXT_W-1:0]   siso_ext_o,
    input  logic                        siso_done_i,
    input  logic [(K+TAIL)*EXT_W-1:0]   siso_ext_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [K-1:0]                data_o,
    output logic [ITER_W-1:0]           iter_used_o
);

    localparam int N  = K + TAIL;
    localparam int SW = EXT_W + 2;
    localparam int BW = (LLR_W > 1) ? $clog2(LLR_W) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DEC1, S_DEC2, S_CHECK, S_OUT} state_t;

    state_t                r_state, w_next;
    logic [BW-1:0]         r_beat;
    logic [N*LLR_W-1:0]    r_sys, r_par1, r_par2;
    logic [N*EXT_W-1:0]    r_ext12, r_ext21;
    logic [N-1:0]          r_prevHard;
    logic [ITER_W-1:0]     r_maxIter, r_iter;
    logic                  r_early, r_start, r_sel;
    logic [N*LLR_W-1:0]    r_sysOut, r_encOut;
    logic [N*EXT_W-1:0]    r_extOut;
    logic [K-1:0]          r_data;

    logic                  w_accept, w_lastBeat, w_dec1Done, w_dec2Done, w_stop;
    logic [BW-1:0]         w_beatIdx;
    logic [N*LLR_W-1:0]    w_sysNx, w_par1Nx, w_par2Nx, w_interSys;
    logic [N*EXT_W-1:0]    w_ext21Eff, w_deint, w_ext12Nx, w_interExt;
    logic signed [SW-1:0]  w_sum [N];
    logic [N-1:0]          w_hard;
    logic [ITER_W-1:0]     w_iterNx, w_limit;

    assign w_accept   = in_valid_i & in_ready_o;
    assign w_beatIdx  = (r_state == S_IDLE) ? '0 : r_beat;
    assign w_lastBeat = (w_beatIdx == BW'(LLR_W - 1));
    assign w_dec1Done = (r_state == S_DEC1) & siso_done_i & ~r_start;
    assign w_dec2Done = (r_state == S_DEC2) & siso_done_i & ~r_start;
    assign w_iterNx   = r_iter + ITER_W'(1);
    assign w_limit    = (r_maxIter == '0) ? ITER_W'(1) : r_maxIter;
    assign w_ext12Nx  = w_dec1Done ? siso_ext_i : r_ext12;
    // A frame still being loaded starts DEC1 with ext21 already treated as zero.
    assign w_ext21Eff = (r_state == S_IDLE || r_state == S_LOAD) ? '0 : r_ext21;

    always_comb begin
        w_sysNx  = r_sys;
        w_par1Nx = r_par1;
        w_par2Nx = r_par2;
        if (w_accept) begin
            for (int j = 0; j < N; j++) begin
                w_sysNx[j*LLR_W + int'(w_beatIdx)]  = data_i[2*N + j];
                w_par1Nx[j*LLR_W + int'(w_beatIdx)] = data_i[N + j];
                w_par2Nx[j*LLR_W + int'(w_beatIdx)] = data_i[j];
            end
        end
    end

    always_comb begin
        w_deint    = '0;
        w_interSys = '0;
        w_interExt = '0;
        for (int i = 0; i < N; i++) begin
            w_deint[int'(PERM[i*IDX_W +: IDX_W])*EXT_W +: EXT_W] = w_ext21Eff[i*EXT_W +: EXT_W];
            w_interSys[i*LLR_W +: LLR_W] = r_sys[int'(PERM[i*IDX_W +: IDX_W])*LLR_W +: LLR_W];
            w_interExt[i*EXT_W +: EXT_W] = w_ext12Nx[int'(PERM[i*IDX_W +: IDX_W])*EXT_W +: EXT_W];
        end
    end

    // Posterior sum per natural position; hard decision is strictly positive.
    always_comb begin
        w_hard = '0;
        for (int j = 0; j < N; j++) begin
            w_sum[j] = {{(SW-LLR_W){r_sys[j*LLR_W + LLR_W - 1]}}, r_sys[j*LLR_W +: LLR_W]}
                     + {{2{r_ext12[j*EXT_W + EXT_W - 1]}}, r_ext12[j*EXT_W +: EXT_W]}
                     + {{2{w_deint[j*EXT_W + EXT_W - 1]}}, w_deint[j*EXT_W +: EXT_W]};
            w_hard[j] = (w_sum[j] > 0);
        end
    end

    assign w_stop = (w_iterNx == w_limit) ||
                    (r_early && (w_iterNx >= ITER_W'(2)) && (w_hard == r_prevHard));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_LOAD: if (w_accept) w_next = w_lastBeat ? S_DEC1 : S_LOAD;
            S_DEC1:         if (w_dec1Done) w_next = S_DEC2;
            S_DEC2:         if (w_dec2Done) w_next = S_CHECK;
            S_CHECK:        w_next = w_stop ? S_OUT : S_DEC1;
            S_OUT:          if (out_ready_i) w_next = S_IDLE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_sys      <= '0;
            r_par1     <= '0;
            r_par2     <= '0;
            r_ext12    <= '0;
            r_ext21    <= '0;
            r_prevHard <= '0;
            r_maxIter  <= '0;
            r_iter     <= '0;
            r_early    <= 1'b0;
            r_start    <= 1'b0;
            r_sel      <= 1'b0;
            r_sysOut   <= '0;
            r_encOut   <= '0;
            r_extOut   <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_next;
            r_start <= 1'b0;
            if (w_accept) begin
                r_sys  <= w_sysNx;
                r_par1 <= w_par1Nx;
                r_par2 <= w_par2Nx;
                r_beat <= w_lastBeat ? '0 : w_beatIdx + BW'(1);
                if (r_state == S_IDLE) begin
                    r_maxIter <= max_iter_i;
                    r_early   <= early_en_i;
                end
                if (w_lastBeat) begin
                    r_iter  <= '0;
                    r_ext21 <= '0;
                end
            end
            // SISO inputs are captured on entry so they stay frozen for the whole half-iteration.
            if (w_next == S_DEC1 && r_state != S_DEC1) begin
                r_start  <= 1'b1;
                r_sel    <= 1'b0;
                r_sysOut <= w_sysNx;
                r_encOut <= w_par1Nx;
                r_extOut <= w_deint;
            end
            if (w_next == S_DEC2 && r_state != S_DEC2) begin
                r_start  <= 1'b1;
                r_sel    <= 1'b1;
                r_sysOut <= w_interSys;
                r_encOut <= r_par2;
                r_extOut <= w_interExt;
            end
            if (w_dec1Done) r_ext12 <= siso_ext_i;
            if (w_dec2Done) r_ext21 <= siso_ext_i;
            if (r_state == S_CHECK) begin
                r_iter <= w_iterNx;
                if (w_stop) r_data <= w_hard[K-1:0];
                else        r_prevHard <= w_hard;
            end
        end
    end

    assign in_ready_o   = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign out_valid_o  = (r_state == S_OUT);
    assign siso_start_o = r_start;
    assign siso_sel_o   = r_sel;
    assign siso_sys_o   = r_sysOut;
    assign siso_enc_o   = r_encOut;
    assign siso_ext_o   = r_extOut;
    assign data_o       = r_data;
    assign iter_used_o  = r_iter;

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Randomised bench for turbo_iter_ctrl with an array-based decoding model and a
// behavioural SISO that returns chosen extrinsic values.
module tb_turbo_iter_ctrl;

    localparam int K = 5, TAIL = 2, N = 7, LLR_W = 4, EXT_W = 10, IDX_W = 3, ITER_W = 6;

    logic                clk_p_i = 1'b0;
    logic                reset_n_i = 1'b0;
    logic                in_valid_i = 1'b0;
    logic                in_ready_o;
    logic [3*N-1:0]      data_i = '0;
    logic [ITER_W-1:0]   max_iter_i = '0;
    logic                early_en_i = 1'b0;
    logic                siso_start_o, siso_sel_o;
    logic [N*LLR_W-1:0]  siso_sys_o, siso_enc_o;
    logic [N*EXT_W-1:0]  siso_ext_o;
    logic                siso_done_i = 1'b0;
    logic [N*EXT_W-1:0]  siso_ext_i = '0;
    logic                out_valid_o;
    logic                out_ready_i = 1'b0;
    logic [K-1:0]        data_o;
    logic [ITER_W-1:0]   iter_used_o;

    turbo_iter_ctrl dut (
        .clk_p_i(clk_p_i), .reset_n_i(reset_n_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .data_i(data_i),
        .max_iter_i(max_iter_i), .early_en_i(early_en_i),
        .siso_start_o(siso_start_o), .siso_sel_o(siso_sel_o),
        .siso_sys_o(siso_sys_o), .siso_enc_o(siso_enc_o), .siso_ext_o(siso_ext_o),
        .siso_done_i(siso_done_i), .siso_ext_i(siso_ext_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .iter_used_o(iter_used_o)
    );

    always #5 clk_p_i = ~clk_p_i;

    int compared = 0;
    int mismatched = 0;
    int perm [N];
    int pinv [N];
    int tSys [N];
    int tP1 [N];
    int tP2 [N];
    int mExt12 [N];
    int mExt21 [N];
    bit gAbort = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [N*LLR_W-1:0] packLlr(input int a [N]);
        logic [N*LLR_W-1:0] r;
        logic [31:0] t;
        r = '0;
        for (int j = 0; j < N; j++) begin
            t = a[j];
            r[j*LLR_W +: LLR_W] = t[LLR_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [N*EXT_W-1:0] packExt(input int a [N]);
        logic [N*EXT_W-1:0] r;
        logic [31:0] t;
        r = '0;
        for (int j = 0; j < N; j++) begin
            t = a[j];
            r[j*EXT_W +: EXT_W] = t[EXT_W-1:0];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk_p_i);
        #1;
    endtask

    task automatic applyReset(input bit checkIt);
        reset_n_i   = 1'b0;
        in_valid_i  = 1'b0;
        siso_done_i = 1'b0;
        out_ready_i = 1'b0;
        #2;
        if (checkIt) begin
            checkOutput("rst_in_ready", in_ready_o, 1);
            checkOutput("rst_out_valid", out_valid_o, 0);
            checkOutput("rst_start", siso_start_o, 0);
            checkOutput("rst_sel", siso_sel_o, 0);
            checkOutput("rst_data", data_o, 0);
            checkOutput("rst_iter", iter_used_o, 0);
            checkOutput("rst_sys", siso_sys_o, 0);
            checkOutput("rst_ext", siso_ext_o, 0);
        end
        @(posedge clk_p_i);
        #1;
        reset_n_i = 1'b1;
        step();
    endtask

    // Drives the bit-planes; abortBeat < LLR_W pulls reset while that beat is on the bus.
    task automatic applyStimulus(input int maxIter, input bit early, input int abortBeat);
        logic [31:0] t;
        for (int b = 0; b < LLR_W; b++) begin
            in_valid_i = 1'b1;
            for (int j = 0; j < N; j++) begin
                t = tSys[j]; data_i[2*N + j] = t[b];
                t = tP1[j];  data_i[N + j]   = t[b];
                t = tP2[j];  data_i[j]       = t[b];
            end
            if (b == 0) begin
                max_iter_i = ITER_W'(maxIter);
                early_en_i = early;
            end else begin
                max_iter_i = ITER_W'($urandom_range(0, 63));
                early_en_i = 1'($urandom);
            end
            if (b == abortBeat) begin
                applyReset(1);
                return;
            end
            if (b == 0) checkOutput("load_ready", in_ready_o, 1);
            step();
        end
        in_valid_i = 1'b0;
        for (int i = 0; i < N; i++) mExt21[i] = 0;
    endtask

    task automatic waitStart(input string tag);
        for (int c = 0; c < 40; c++) begin
            if (siso_start_o) return;
            step();
        end
        checkOutput({tag, "_start_timeout"}, 0, 1);
        gAbort = 1;
    endtask

    // One half-iteration: checks the launched SISO inputs, then answers with extrinsics.
    task automatic runSiso(input bit sel, input int extMode, input int extConst);
        int tmp [N];
        int res [N];
        logic [N*LLR_W-1:0] expSys, expEnc;
        logic [N*EXT_W-1:0] expExt;
        waitStart(sel ? "dec2" : "dec1");
        if (gAbort) return;
        if (!sel) begin
            expSys = packLlr(tSys);
            expEnc = packLlr(tP1);
            for (int i = 0; i < N; i++) tmp[perm[i]] = mExt21[i];
            expExt = packExt(tmp);
        end else begin
            for (int i = 0; i < N; i++) tmp[i] = tSys[perm[i]];
            expSys = packLlr(tmp);
            expEnc = packLlr(tP2);
            for (int i = 0; i < N; i++) tmp[i] = mExt12[perm[i]];
            expExt = packExt(tmp);
        end
        checkOutput("siso_sel", siso_sel_o, sel);
        checkOutput("siso_sys", siso_sys_o, expSys);
        checkOutput("siso_enc", siso_enc_o, expEnc);
        checkOutput("siso_ext", siso_ext_o, expExt);
        for (int i = 0; i < N; i++)
            res[i] = (extMode == 0) ? int'($urandom_range(0, 40)) - 20 : extConst;
        if ($urandom_range(0, 1) == 1) begin
            siso_done_i = 1'b1;
            siso_ext_i  = {$urandom, $urandom, $urandom};
        end
        step();
        siso_done_i = 1'b0;
        checkOutput("start_one_cycle", siso_start_o, 0);
        repeat ($urandom_range(0, 3)) step();
        checkOutput("siso_sys_hold", siso_sys_o, expSys);
        checkOutput("siso_ext_hold", siso_ext_o, expExt);
        siso_done_i = 1'b1;
        siso_ext_i  = packExt(res);
        step();
        siso_done_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!sel) mExt12[i] = res[i];
            else      mExt21[i] = res[i];
        end
    endtask

    task automatic runFrame(input int maxIter, input bit early, input int extMode,
                            input int extConst, input int hold);
        int limit, it, s;
        logic [N-1:0] hard, prev;
        bit found;
        applyStimulus(maxIter, early, LLR_W);
        limit = (maxIter == 0) ? 1 : maxIter;
        it = 0;
        prev = '0;
        while (1) begin
            runSiso(0, extMode, extConst);
            if (gAbort) break;
            runSiso(1, extMode, extConst);
            if (gAbort) break;
            for (int j = 0; j < N; j++) begin
                s = tSys[j] + mExt12[j] + mExt21[pinv[j]];
                hard[j] = (s > 0);
            end
            it++;
            if (it == limit || (early && it >= 2 && hard == prev)) break;
            prev = hard;
        end
        if (gAbort) begin
            applyReset(0);
            gAbort = 0;
            return;
        end
        found = 0;
        for (int c = 0; c < 6 && !found; c++) begin
            if (out_valid_o) found = 1;
            else step();
        end
        checkOutput("out_valid", out_valid_o, 1);
        checkOutput("data_o", data_o, hard[K-1:0]);
        checkOutput("iter_used", iter_used_o, it);
        checkOutput("out_in_ready", in_ready_o, 0);
        for (int c = 0; c < hold; c++) begin
            in_valid_i = 1'b1;
            data_i = 21'($urandom);
            step();
            checkOutput("hold_valid", out_valid_o, 1);
            checkOutput("hold_data", data_o, hard[K-1:0]);
            checkOutput("hold_in_ready", in_ready_o, 0);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checkOutput("after_out_valid", out_valid_o, 0);
        checkOutput("after_in_ready", in_ready_o, 1);
        if (!found) begin
            applyReset(0);
        end
    endtask

    task automatic randomFrameData();
        for (int j = 0; j < N; j++) begin
            tSys[j] = int'($urandom_range(0, 15)) - 8;
            tP1[j]  = int'($urandom_range(0, 15)) - 8;
            tP2[j]  = int'($urandom_range(0, 15)) - 8;
        end
    endtask

    initial begin
        logic [N*IDX_W-1:0] permBits;
        permBits = 21'b100001101010110011000;
        for (int i = 0; i < N; i++) begin
            perm[i] = int'(permBits[i*IDX_W +: IDX_W]);
            pinv[perm[i]] = i;
        end
        for (int i = 0; i < N; i++) begin mExt12[i] = 0; mExt21[i] = 0; end

        applyReset(1);

        for (int j = 0; j < N; j++) begin tSys[j] = -1; tP1[j] = 0; tP2[j] = 0; end
        runFrame(1, 0, 1, 0, 1);

        for (int j = 0; j < N; j++) tSys[j] = 3;
        runFrame(3, 0, 1, 1, 5);
        runFrame(10, 1, 1, 1, 2);

        randomFrameData();
        for (int j = 0; j < N; j++) tSys[j] = j;
        runFrame(2, 0, 0, 0, 0);

        randomFrameData();
        applyStimulus(3, 0, LLR_W);
        runSiso(0, 0, 0);
        waitStart("dec2_rst");
        applyReset(1);
        randomFrameData();
        runFrame(2, 1, 0, 0, 1);

        randomFrameData();
        applyStimulus(2, 0, 2);
        randomFrameData();
        runFrame(2, 0, 0, 0, 0);

        for (int f = 0; f < 20; f++) begin
            randomFrameData();
            runFrame(int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
